// File: rtl/conversor_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// The converter top uses these defaults. Its optional leading-zero blanking
// is controlled by the BLANK_CEROS_EN macro.
package conversor_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} estado_t;

  localparam int BCD_W      = 4;
  localparam int BIN_W_DEF  = 13;
  localparam int DIGITS_DEF = 4;
  localparam int CNT_W      = $clog2(BIN_W_DEF + 1);

endpackage

// File: rtl/ajuste_dabble.sv
// Double-dabble nibble correction. A BCD digit of 5 or more gets 3 added
// before the shift, so that the shift carries correctly into the next digit.
module ajuste_dabble
  import conversor_pkg::*;
(
  input  logic [BCD_W-1:0] nib_in,
  output logic [BCD_W-1:0] nib_out
);

  // The input never exceeds 9, so the 4-bit sum cannot overflow.
  always_comb begin
    nib_out = nib_in;
    if (nib_in >= 4'd5) begin
      nib_out = nib_in + 4'd3;
    end
  end

endmodule

// File: rtl/conversor_bin_bcd.sv
// Sequential double-dabble converter from the adder result to packed BCD.
// A start pulse begins a conversion, and each clock performs one shift step.
// Optional macro BLANK_CEROS_EN registers a leading-zero mask on 'blank'.
// Without that macro, 'blank' is tied to zero.
module conversor_bin_bcd
  import conversor_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGITS*BCD_W-1:0]   bcd_out,
  output logic [DIGITS-1:0]         blank
);

  localparam int BCD_BITS = DIGITS * BCD_W;
  localparam int SH_W     = BCD_BITS + BIN_W;
  localparam int CNT_BITS = $clog2(BIN_W + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(BIN_W);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  estado_t             state;
  estado_t             state_next;
  logic [SH_W-1:0]     sh_reg;
  logic [SH_W-1:0]     sh_next;
  logic [SH_W-1:0]     sh_adj;
  logic [BCD_BITS-1:0] bcd_adj;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_next;

  // One corrector per BCD digit of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    ajuste_dabble u_ajuste (
      .nib_in  (sh_reg[BIN_W + g*BCD_W +: BCD_W]),
      .nib_out (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  assign sh_adj = {bcd_adj, sh_reg[BIN_W-1:0]};

  // Next-state and datapath logic. IDLE loads the operand, SHIFT performs one
  // step per clock, and FIN lasts a single cycle while results are published.
  always_comb begin
    state_next = state;
    sh_next    = sh_reg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          sh_next    = {{BCD_BITS{1'b0}}, bin_in};
          cnt_next   = CNT_LOAD;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sh_next  = sh_adj << 1;
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. A reset aborts any conversion in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register and step counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_reg <= '0;
      cnt    <= '0;
    end else begin
      sh_reg <= sh_next;
      cnt    <= cnt_next;
    end
  end

  // Output registers lag the state by one cycle. As a result, busy covers the
  // shift cycles, and done and bcd_out appear together as FIN is left.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      busy <= (state == SHIFT);
      done <= (state == FIN);
      if (state == FIN) begin
        bcd_out <= sh_reg[SH_W-1 -: BCD_BITS];
      end
    end
  end

`ifdef BLANK_CEROS_EN
  logic [DIGITS-1:0] blank_next;
  logic              lead_zero;

  // Scan from the most-significant digit down to find the leading zeros.
  // Digit 0 always stays visible, so a value of zero displays as "0".
  always_comb begin
    blank_next = '0;
    lead_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero     = lead_zero & (sh_reg[BIN_W + i*BCD_W +: BCD_W] == '0);
      blank_next[i] = lead_zero;
    end
  end

  // The mask is registered together with bcd_out, so both change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blank <= '0;
    end else if (state == FIN) begin
      blank <= blank_next;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Testbench for conversor_bin_bcd, using a scoreboard and a decimal reference model.
// The expected blank mask follows the BLANK_CEROS_EN macro.
`timescale 1ns/1ps
module tb_conversor_bin_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [12:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [3:0]  blank;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    int          value;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  int   bc;
  int   corners[8] = '{0, 8191, 9, 10, 99, 100, 999, 1998};

  // 27 MHz system clock
  always #18.5 clk = ~clk;

  conversor_bin_bcd dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  // The reference model works on decimal digits using plain division.
  function automatic exp_t model(input int v);
    exp_t e;
    int   nd;
    e.value = v;
    e.bcd   = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    nd = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
`ifdef BLANK_CEROS_EN
    e.blank = 4'((8'hF << nd) & 8'hF);
`else
    e.blank = 4'(nd * 0);
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pulse start for one edge. The scoreboard records a result only if one is expected.
  task automatic applyStimulus(input logic [12:0] v, input bit expect_result);
    bin_in = v;
    start  = 1'b1;
    if (expect_result) exp_q.push_back(model(int'(v)));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count negedges after the sampling edge until done, and count busy cycles along the way.
  task automatic waitDone(output int latency, output int busy_cnt);
    latency  = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        latency = k;
        break;
      end
    end
    if (latency < 0) checkOutput("done_timeout", 0, 1);
  endtask

  // Monitor: each done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput($sformatf("bcd_out_%0d", mon_e.value), bcd_out, mon_e.bcd);
        checkOutput($sformatf("blank_%0d", mon_e.value), blank, mon_e.blank);
      end
    end
`ifndef BLANK_CEROS_EN
    if (blank !== 4'b0000) checkOutput("blank_tied_zero", blank, 0);
`endif
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_bcd", bcd_out, 0);
    checkOutput("reset_blank", blank, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single conversion 579");
    applyStimulus(13'd579, 1'b1);
    waitDone(lat, bc);
    checkOutput("latency_579", lat, 14);
    checkOutput("busy_cycles_579", bc, 13);

    $display("[TB] back-to-back 1776 then 1000");
    repeat (3) @(negedge clk);
    applyStimulus(13'd1776, 1'b1);
    waitDone(lat, bc);
    checkOutput("latency_1776", lat, 14);
    applyStimulus(13'd1000, 1'b1);
    waitDone(lat, bc);
    checkOutput("latency_1000_b2b", lat, 14);

    $display("[TB] corner values");
    foreach (corners[i]) begin
      repeat (2) @(negedge clk);
      applyStimulus(13'(corners[i]), 1'b1);
      waitDone(lat, bc);
      checkOutput($sformatf("latency_%0d", corners[i]), lat, 14);
    end

    $display("[TB] start during busy is ignored");
    repeat (2) @(negedge clk);
    applyStimulus(13'd1234, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bin_in = 13'd42;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat, bc);
    repeat (20) @(negedge clk);

    $display("[TB] reset mid-conversion");
    applyStimulus(13'd1998, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_bcd", bcd_out, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(13'd1998, 1'b1);
    waitDone(lat, bc);
    checkOutput("latency_1998_after_abort", lat, 14);

    $display("[TB] random values");
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(13'($urandom_range(0, 8191)), 1'b1);
      waitDone(lat, bc);
      checkOutput("latency_random", lat, 14);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
